// File: rtl/nvme_pcie_nptag.sv
// Non-posted tag manager: allocates control-unit tags, times them out, matches
// requester completions and returns one classified response per request.
module nvme_pcie_nptag #(
    parameter int unsigned NUM_TAGS  = 4,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic                          user_clk,
    input  logic                          user_reset_n,
    input  logic                          user_lnk_up,
    input  logic [TIMEOUT_W-1:0]          regs_nptag_timeout,
    input  logic                          ctl_nptag_req_valid,
    output logic                          nptag_ctl_req_ready,
    output logic [7:0]                    nptag_ctl_req_tag,
    input  logic                          rxrc_nptag_valid,
    input  logic [7:0]                    rxrc_nptag_tag,
    input  logic [63:0]                   rxrc_nptag_data,
    input  logic [7:0]                    rxrc_nptag_datap,
    input  logic [7:0]                    rxrc_nptag_be,
    input  logic [2:0]                    rxrc_nptag_status,
    input  logic                          rxrc_nptag_poison,
    input  logic [3:0]                    rxrc_nptag_errcode,
    output logic                          nptag_rxrc_ack,
    output logic                          nptag_ctl_rsp_valid,
    output logic [7:0]                    nptag_ctl_rsp_tag,
    output logic [2:0]                    nptag_ctl_rsp_code,
    output logic [63:0]                   nptag_ctl_rsp_data,
    output logic [7:0]                    nptag_ctl_rsp_datap,
    output logic [7:0]                    nptag_ctl_rsp_be,
    input  logic                          ctl_nptag_rsp_ack,
    output logic [$clog2(NUM_TAGS):0]     nptag_outstanding,
    output logic                          nptag_unexp_err
);
    localparam int unsigned TW = $clog2(NUM_TAGS);
    localparam logic [TIMEOUT_W-1:0] TimerOne = TIMEOUT_W'(1);

    logic [NUM_TAGS-1:0]  busy_q, busy_d, expired_q, expired_d;
    logic [TIMEOUT_W-1:0] timer_q [NUM_TAGS];
    logic [TIMEOUT_W-1:0] timer_d [NUM_TAGS];

    logic        rsp_valid_q;
    logic [7:0]  rsp_tag_q;
    logic [2:0]  rsp_code_q;
    logic [63:0] rsp_data_q;
    logic [7:0]  rsp_datap_q;
    logic [7:0]  rsp_be_q;
    logic        unexp_q;

    logic [TW-1:0]        free_idx, exp_idx, cpl_idx;
    logic                 any_free, any_exp;
    logic                 alloc, slot_free, cpl_hit, to_fire;
    logic [2:0]           cpl_code;
    logic [TIMEOUT_W-1:0] limit_m1;
    logic [TW:0]          busy_cnt;

    // Lowest free and lowest expired index, plus busy popcount
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        exp_idx  = '0;
        any_exp  = 1'b0;
        busy_cnt = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_idx = TW'(i);
                any_free = 1'b1;
            end
            if (expired_q[i]) begin
                exp_idx = TW'(i);
                any_exp = 1'b1;
            end
        end
        for (int i = 0; i < NUM_TAGS; i++) begin
            busy_cnt = busy_cnt + (TW + 1)'(busy_q[i]);
        end
    end

    always_comb begin
        if (rxrc_nptag_errcode != 4'd0) cpl_code = 3'd1;
        else if (rxrc_nptag_poison)     cpl_code = 3'd2;
        else if (rxrc_nptag_status != 3'd0) cpl_code = 3'd3;
        else                            cpl_code = 3'd0;
    end

    assign nptag_ctl_req_ready = user_lnk_up & any_free;
    assign nptag_ctl_req_tag   = {{(8 - TW){1'b0}}, free_idx};
    assign alloc               = ctl_nptag_req_valid & nptag_ctl_req_ready;
    assign slot_free           = ~rsp_valid_q | ctl_nptag_rsp_ack;
    assign nptag_rxrc_ack      = rxrc_nptag_valid & slot_free;
    assign cpl_idx             = rxrc_nptag_tag[TW-1:0];
    assign cpl_hit             = nptag_rxrc_ack && (rxrc_nptag_tag[7:TW] == '0) && busy_q[cpl_idx];
    // Any accepted completion, even an unexpected one, holds off timeout responses
    assign to_fire             = slot_free & ~nptag_rxrc_ack & any_exp;
    assign limit_m1            = regs_nptag_timeout - TimerOne;

    always_comb begin
        busy_d    = busy_q;
        expired_d = expired_q;
        for (int i = 0; i < NUM_TAGS; i++) begin
            timer_d[i] = timer_q[i];
            if (alloc && free_idx == TW'(i)) begin
                busy_d[i]    = 1'b1;
                expired_d[i] = 1'b0;
                timer_d[i]   = '0;
            end else if (busy_q[i] && !expired_q[i]) begin
                if (regs_nptag_timeout != '0) timer_d[i] = timer_q[i] + TimerOne;
                if (!user_lnk_up ||
                    (regs_nptag_timeout != '0 && timer_q[i] == limit_m1)) begin
                    expired_d[i] = 1'b1;
                end
            end
            if ((cpl_hit && cpl_idx == TW'(i)) || (to_fire && exp_idx == TW'(i))) begin
                busy_d[i]    = 1'b0;
                expired_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            busy_q      <= '0;
            expired_q   <= '0;
            for (int i = 0; i < NUM_TAGS; i++) timer_q[i] <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_code_q  <= '0;
            rsp_data_q  <= '0;
            rsp_datap_q <= '0;
            rsp_be_q    <= '0;
            unexp_q     <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            expired_q <= expired_d;
            for (int i = 0; i < NUM_TAGS; i++) timer_q[i] <= timer_d[i];
            if (nptag_rxrc_ack && !cpl_hit) unexp_q <= 1'b1;
            if (cpl_hit) begin
                rsp_valid_q <= 1'b1;
                rsp_tag_q   <= rxrc_nptag_tag;
                rsp_code_q  <= cpl_code;
                rsp_data_q  <= rxrc_nptag_data;
                rsp_datap_q <= rxrc_nptag_datap;
                rsp_be_q    <= rxrc_nptag_be;
            end else if (to_fire) begin
                rsp_valid_q <= 1'b1;
                rsp_tag_q   <= {{(8 - TW){1'b0}}, exp_idx};
                rsp_code_q  <= 3'd4;
                rsp_data_q  <= '0;
                rsp_datap_q <= 8'hFF;
                rsp_be_q    <= '0;
            end else if (ctl_nptag_rsp_ack) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign nptag_ctl_rsp_valid = rsp_valid_q;
    assign nptag_ctl_rsp_tag   = rsp_tag_q;
    assign nptag_ctl_rsp_code  = rsp_code_q;
    assign nptag_ctl_rsp_data  = rsp_data_q;
    assign nptag_ctl_rsp_datap = rsp_datap_q;
    assign nptag_ctl_rsp_be    = rsp_be_q;
    assign nptag_outstanding   = busy_cnt;
    assign nptag_unexp_err     = unexp_q;

endmodule

// File: tb/tb_nvme_pcie_nptag.sv
// Directed bench for nvme_pcie_nptag: allocation, matching, classification,
// timeout, link-down drain and reset.
module tb_nvme_pcie_nptag;
    logic        user_clk = 1'b0;
    logic        user_reset_n;
    logic        user_lnk_up;
    logic [19:0] regs_nptag_timeout;
    logic        ctl_nptag_req_valid;
    logic        nptag_ctl_req_ready;
    logic [7:0]  nptag_ctl_req_tag;
    logic        rxrc_nptag_valid;
    logic [7:0]  rxrc_nptag_tag;
    logic [63:0] rxrc_nptag_data;
    logic [7:0]  rxrc_nptag_datap;
    logic [7:0]  rxrc_nptag_be;
    logic [2:0]  rxrc_nptag_status;
    logic        rxrc_nptag_poison;
    logic [3:0]  rxrc_nptag_errcode;
    logic        nptag_rxrc_ack;
    logic        nptag_ctl_rsp_valid;
    logic [7:0]  nptag_ctl_rsp_tag;
    logic [2:0]  nptag_ctl_rsp_code;
    logic [63:0] nptag_ctl_rsp_data;
    logic [7:0]  nptag_ctl_rsp_datap;
    logic [7:0]  nptag_ctl_rsp_be;
    logic        ctl_nptag_rsp_ack;
    logic [2:0]  nptag_outstanding;
    logic        nptag_unexp_err;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 user_clk = ~user_clk;

    nvme_pcie_nptag #(.NUM_TAGS(4), .TIMEOUT_W(20)) dut (
        .user_clk            (user_clk),
        .user_reset_n        (user_reset_n),
        .user_lnk_up         (user_lnk_up),
        .regs_nptag_timeout  (regs_nptag_timeout),
        .ctl_nptag_req_valid (ctl_nptag_req_valid),
        .nptag_ctl_req_ready (nptag_ctl_req_ready),
        .nptag_ctl_req_tag   (nptag_ctl_req_tag),
        .rxrc_nptag_valid    (rxrc_nptag_valid),
        .rxrc_nptag_tag      (rxrc_nptag_tag),
        .rxrc_nptag_data     (rxrc_nptag_data),
        .rxrc_nptag_datap    (rxrc_nptag_datap),
        .rxrc_nptag_be       (rxrc_nptag_be),
        .rxrc_nptag_status   (rxrc_nptag_status),
        .rxrc_nptag_poison   (rxrc_nptag_poison),
        .rxrc_nptag_errcode  (rxrc_nptag_errcode),
        .nptag_rxrc_ack      (nptag_rxrc_ack),
        .nptag_ctl_rsp_valid (nptag_ctl_rsp_valid),
        .nptag_ctl_rsp_tag   (nptag_ctl_rsp_tag),
        .nptag_ctl_rsp_code  (nptag_ctl_rsp_code),
        .nptag_ctl_rsp_data  (nptag_ctl_rsp_data),
        .nptag_ctl_rsp_datap (nptag_ctl_rsp_datap),
        .nptag_ctl_rsp_be    (nptag_ctl_rsp_be),
        .ctl_nptag_rsp_ack   (ctl_nptag_rsp_ack),
        .nptag_outstanding   (nptag_outstanding),
        .nptag_unexp_err     (nptag_unexp_err)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge user_clk);
        #1;
    endtask

    task automatic alloc_one(input logic [7:0] exp_tag);
        ctl_nptag_req_valid = 1'b1;
        #1;
        chk_eq("alloc_ready", nptag_ctl_req_ready, 1);
        chk_eq("alloc_tag", nptag_ctl_req_tag, exp_tag);
        cyc();
        ctl_nptag_req_valid = 1'b0;
    endtask

    task automatic send_cpl(input logic [7:0] tag, input logic [63:0] data, input logic [7:0] datap,
                            input logic [7:0] be, input logic [2:0] status, input logic poison,
                            input logic [3:0] errcode);
        rxrc_nptag_valid   = 1'b1;
        rxrc_nptag_tag     = tag;
        rxrc_nptag_data    = data;
        rxrc_nptag_datap   = datap;
        rxrc_nptag_be      = be;
        rxrc_nptag_status  = status;
        rxrc_nptag_poison  = poison;
        rxrc_nptag_errcode = errcode;
        #1;
        chk_eq("cpl_ack", nptag_rxrc_ack, 1);
        cyc();
        rxrc_nptag_valid = 1'b0;
    endtask

    task automatic ack_rsp();
        ctl_nptag_rsp_ack = 1'b1;
        cyc();
        ctl_nptag_rsp_ack = 1'b0;
        chk_eq("rsp_cleared", nptag_ctl_rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        user_reset_n = 1'b0;  user_lnk_up = 1'b0;  regs_nptag_timeout = '0;
        ctl_nptag_req_valid = 1'b0;  ctl_nptag_rsp_ack = 1'b0;
        rxrc_nptag_valid = 1'b0;  rxrc_nptag_tag = '0;  rxrc_nptag_data = '0;
        rxrc_nptag_datap = '0;  rxrc_nptag_be = '0;  rxrc_nptag_status = '0;
        rxrc_nptag_poison = 1'b0;  rxrc_nptag_errcode = '0;
        repeat (3) cyc();
        chk_eq("rst_rsp_valid", nptag_ctl_rsp_valid, 0);
        chk_eq("rst_rsp_datap", nptag_ctl_rsp_datap, 0);
        chk_eq("rst_outstanding", nptag_outstanding, 0);
        chk_eq("rst_unexp", nptag_unexp_err, 0);
        chk_eq("rst_ready_lnkdown", nptag_ctl_req_ready, 0);
        chk_eq("rst_req_tag", nptag_ctl_req_tag, 0);
        user_reset_n = 1'b1;  user_lnk_up = 1'b1;
        cyc();

        // Fill all four tags back-to-back
        for (int i = 0; i < 4; i++) alloc_one(8'(i));
        #1;
        chk_eq("full_ready", nptag_ctl_req_ready, 0);
        chk_eq("full_outstanding", nptag_outstanding, 4);

        send_cpl(8'h02, 64'h1122334455667788, 8'h5A, 8'hFF, 3'd0, 1'b0, 4'd0);
        chk_eq("ok_valid", nptag_ctl_rsp_valid, 1);
        chk_eq("ok_tag", nptag_ctl_rsp_tag, 8'h02);
        chk_eq("ok_code", nptag_ctl_rsp_code, 0);
        chk_eq("ok_data", nptag_ctl_rsp_data, 64'h1122334455667788);
        chk_eq("ok_datap", nptag_ctl_rsp_datap, 8'h5A);
        chk_eq("ok_be", nptag_ctl_rsp_be, 8'hFF);
        chk_eq("ok_outstanding", nptag_outstanding, 3);
        ack_rsp();
        alloc_one(8'h02);
        chk_eq("realloc_outstanding", nptag_outstanding, 4);

        // Out-of-range tag, then a tag that is free
        send_cpl(8'h40, 64'hDEAD, 8'h00, 8'h0F, 3'd0, 1'b0, 4'd0);
        chk_eq("unexp40_norsp", nptag_ctl_rsp_valid, 0);
        chk_eq("unexp40_flag", nptag_unexp_err, 1);
        chk_eq("unexp40_outstanding", nptag_outstanding, 4);
        send_cpl(8'h01, 64'hA5A5_0000_1111_2222, 8'h33, 8'h0F, 3'd0, 1'b0, 4'd0);
        chk_eq("t1_tag", nptag_ctl_rsp_tag, 8'h01);
        ack_rsp();
        chk_eq("t1_outstanding", nptag_outstanding, 3);
        send_cpl(8'h01, 64'h1, 8'h00, 8'h01, 3'd0, 1'b0, 4'd0);
        chk_eq("unexp01_norsp", nptag_ctl_rsp_valid, 0);
        chk_eq("unexp01_sticky", nptag_unexp_err, 1);
        chk_eq("unexp01_outstanding", nptag_outstanding, 3);

        // Errcode beats poison; backpressure holds the response and the completion
        alloc_one(8'h01);
        send_cpl(8'h01, 64'hCAFE_F00D_0000_0001, 8'h77, 8'hF0, 3'd0, 1'b1, 4'h3);
        chk_eq("err_code", nptag_ctl_rsp_code, 1);
        chk_eq("err_tag", nptag_ctl_rsp_tag, 8'h01);
        rxrc_nptag_valid = 1'b1;  rxrc_nptag_tag = 8'h03;  rxrc_nptag_data = 64'h33;
        rxrc_nptag_datap = 8'h11;  rxrc_nptag_be = 8'h01;  rxrc_nptag_status = 3'd2;
        rxrc_nptag_poison = 1'b0;  rxrc_nptag_errcode = 4'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_eq("hold_noack", nptag_rxrc_ack, 0);
            chk_eq("hold_code", nptag_ctl_rsp_code, 1);
            chk_eq("hold_data", nptag_ctl_rsp_data, 64'hCAFE_F00D_0000_0001);
            cyc();
        end
        ctl_nptag_rsp_ack = 1'b1;
        #1;
        chk_eq("backtoback_ack", nptag_rxrc_ack, 1);
        cyc();
        ctl_nptag_rsp_ack = 1'b0;  rxrc_nptag_valid = 1'b0;
        chk_eq("status_valid", nptag_ctl_rsp_valid, 1);
        chk_eq("status_tag", nptag_ctl_rsp_tag, 8'h03);
        chk_eq("status_code", nptag_ctl_rsp_code, 3);
        ack_rsp();
        send_cpl(8'h00, 64'h5, 8'h00, 8'h01, 3'd0, 1'b1, 4'd0);
        chk_eq("poison_code", nptag_ctl_rsp_code, 2);
        ack_rsp();
        chk_eq("pre_rst_outstanding", nptag_outstanding, 1);

        // Asynchronous reset mid-operation
        user_reset_n = 1'b0;
        #1;
        chk_eq("midrst_outstanding", nptag_outstanding, 0);
        chk_eq("midrst_unexp", nptag_unexp_err, 0);
        cyc();
        user_reset_n = 1'b1;
        cyc();

        // Timeout with limit 10
        regs_nptag_timeout = 20'd10;
        alloc_one(8'h00);
        n = 0;
        while (!nptag_ctl_rsp_valid && n < 30) begin
            cyc();
            n++;
        end
        chk_eq("to_latency_10_11", 64'((n == 10) || (n == 11)), 1);
        chk_eq("to_code", nptag_ctl_rsp_code, 4);
        chk_eq("to_tag", nptag_ctl_rsp_tag, 8'h00);
        chk_eq("to_data", nptag_ctl_rsp_data, 0);
        chk_eq("to_datap", nptag_ctl_rsp_datap, 8'hFF);
        chk_eq("to_be", nptag_ctl_rsp_be, 0);
        chk_eq("to_outstanding", nptag_outstanding, 0);
        ack_rsp();
        send_cpl(8'h00, 64'h9, 8'h00, 8'h01, 3'd0, 1'b0, 4'd0);
        chk_eq("late_norsp", nptag_ctl_rsp_valid, 0);
        chk_eq("late_unexp", nptag_unexp_err, 1);
        regs_nptag_timeout = '0;

        // Link down drains busy tags as timeouts in index order
        for (int i = 0; i < 3; i++) alloc_one(8'(i));
        chk_eq("ld_outstanding", nptag_outstanding, 3);
        user_lnk_up = 1'b0;
        #1;
        chk_eq("ld_ready", nptag_ctl_req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!nptag_ctl_rsp_valid && n < 10) begin
                cyc();
                n++;
            end
            chk_eq("ld_valid", nptag_ctl_rsp_valid, 1);
            chk_eq("ld_tag", nptag_ctl_rsp_tag, 8'(i));
            chk_eq("ld_code", nptag_ctl_rsp_code, 4);
            ctl_nptag_rsp_ack = 1'b1;
            cyc();
            ctl_nptag_rsp_ack = 1'b0;
        end
        chk_eq("ld_drained", nptag_outstanding, 0);
        chk_eq("ld_rsp_done", nptag_ctl_rsp_valid, 0);
        chk_eq("ld_ready_still0", nptag_ctl_req_ready, 0);
        user_lnk_up = 1'b1;
        #1;
        chk_eq("lu_ready", nptag_ctl_req_ready, 1);

        // Allocation and free in the same cycle
        alloc_one(8'h00);
        alloc_one(8'h01);
        ctl_nptag_req_valid = 1'b1;
        rxrc_nptag_valid = 1'b1;  rxrc_nptag_tag = 8'h00;  rxrc_nptag_status = 3'd0;
        rxrc_nptag_poison = 1'b0;  rxrc_nptag_errcode = 4'd0;
        #1;
        chk_eq("same_req_tag", nptag_ctl_req_tag, 8'h02);
        chk_eq("same_ack", nptag_rxrc_ack, 1);
        cyc();
        ctl_nptag_req_valid = 1'b0;  rxrc_nptag_valid = 1'b0;
        #1;
        chk_eq("same_outstanding", nptag_outstanding, 2);
        chk_eq("same_rsp_tag", nptag_ctl_rsp_tag, 8'h00);
        chk_eq("same_freed_tag", nptag_ctl_req_tag, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nvme_pcie_nptag.md
Name: nvme_pcie_nptag

Overview:
- Tag manager and completion scheduler for non-posted requests issued by the control unit over PCIe.
- Allocates control-unit tags, which always have tag[7:6]=0, and tracks each outstanding request with a per-tag timer.
- Consumes completions from the requester-completion receive path and matches them to outstanding tags.
- Returns one classified response per request to the control unit: normal, error, poisoned, or timed out.

Parameters:
- NUM_TAGS, 4, outstanding non-posted requests supported; power of two, 2..16; tag index width TW=log2(NUM_TAGS).
- TIMEOUT_W, 20, width of per-tag timeout counters and of the timeout limit.

Ports:
- user_clk  in  1  clock.
- user_reset_n  in  1  asynchronous active-low reset.
- user_lnk_up  in  1  PCIe link up.
- regs_nptag_timeout  in  TIMEOUT_W  timeout limit in user_clk cycles; 0 disables timeout.
- ctl_nptag_req_valid  in  1  control unit requests a tag.
- nptag_ctl_req_ready  out  1  tag available.
- nptag_ctl_req_tag  out  8  allocated tag; valid while ready.
- rxrc_nptag_valid  in  1  completion available.
- rxrc_nptag_tag  in  8  completion tag.
- rxrc_nptag_data  in  64  completion payload.
- rxrc_nptag_datap  in  8  payload parity.
- rxrc_nptag_be  in  8  byte enables.
- rxrc_nptag_status  in  3  completion status.
- rxrc_nptag_poison  in  1  poisoned completion.
- rxrc_nptag_errcode  in  4  core error code.
- nptag_rxrc_ack  out  1  completion consumed (1-cycle pulse).
- nptag_ctl_rsp_valid  out  1  response valid.
- nptag_ctl_rsp_tag  out  8  response tag.
- nptag_ctl_rsp_code  out  3  0=ok, 1=errcode, 2=poison, 3=status≠0, 4=timeout.
- nptag_ctl_rsp_data  out  64  payload; 0 for timeout.
- nptag_ctl_rsp_datap  out  8  payload parity; 8'hFF for timeout (odd parity of zero).
- nptag_ctl_rsp_be  out  8  byte enables; 0 for timeout.
- ctl_nptag_rsp_ack  in  1  response consumed.
- nptag_outstanding  out  TW+1  count of busy tags.
- nptag_unexp_err  out  1  sticky: completion for an unknown or free tag.

Behaviour:
- Reset values: all outputs 0 except nptag_ctl_rsp_datap=0; busy/expired vectors and timers 0.
- Allocation:
  - req_ready = user_lnk_up & |~busy_q.
  - req_tag = {0, lowest free index}.
  - A handshake (valid & ready) sets busy[idx] and clears timer[idx] at the next edge.
  - One allocation per cycle.
- Response register:
  - Single entry, held until rsp_ack.
  - A new response may load in the same cycle rsp_ack is seen (slot_free = ~rsp_valid_q | rsp_ack).
- Completion acceptance:
  - nptag_rxrc_ack = rxrc_nptag_valid & slot_free.
  - The accepted completion loads the response at the next edge (latency 1).
- Matching:
  - If tag[7:TW]≠0 or ~busy[idx]: ack, drop, set unexp_err, no response.
  - Otherwise clear busy[idx] and expired[idx] and load the response.
  - Code priority: errcode≠0 → 1; poison → 2; status≠0 → 3; else 0.
- Timers:
  - Each busy, non-expired tag increments every cycle while the limit≠0.
  - When timer == limit−1, expired[idx] is set at the next edge.
- Timeout response:
  - When slot_free and no completion is accepted that cycle, the lowest expired index issues a code-4 response and frees the tag.
  - Completions have priority over timeout responses.
  - A late completion for that tag is then unexpected.
- Link down:
  - user_lnk_up=0 sets expired for every busy tag next cycle; req_ready=0.
  - Expired tags drain as timeout responses.
  - Completions still acked and matched.
- Same-cycle events:
  - A tag freed this cycle is not reallocatable until the next cycle, because allocation uses busy_q.
  - Allocation and free in one cycle leave outstanding unchanged.
- Counter: nptag_outstanding = popcount(busy_q).
- Reset mid-operation: all state cleared; in-flight completions arriving after reset are unexpected.

Test Plan:
- Allocate 4 tags back-to-back → tags 0x00..0x03, req_ready=0 on cycle 5, outstanding=4.
- Completion tag 0x02, status 0, data 0x1122334455667788, be 0xFF → rsp_valid next cycle, code 0, data matches; outstanding 4→3; next allocation returns 0x02.
- Completion tag 0x40, then completion tag 0x01 with tag 1 free → both acked, no response, unexp_err=1 and sticky.
- limit=10, allocate tag 0, no completion → code-4 response 10–11 cycles after allocation; late completion tag 0 → unexp_err=1.
- Tag 1 poison=1 and errcode=4'h3 in the same completion → code 1; hold rsp_ack low 5 cycles → rxrc ack held low, response stable.
- 3 tags busy, drop user_lnk_up → three code-4 responses in index order, req_ready=0, outstanding reaches 0.
